// File: rtl/note_seq_pkg.sv
// Shared types, tone-divisor table and key helpers for the note sequencer.
// Pure declarations; no latency, no flow control.
package note_seq_pkg;

    localparam int NUM_KEYS = 13;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // round(12 MHz / f) for C3..C4
    localparam logic [18:0] NOTE_DIV [NUM_KEYS] = '{
        19'd91735, 19'd86585, 19'd81726, 19'd77139, 19'd72809, 19'd68723, 19'd64865,
        19'd61225, 19'd57789, 19'd54545, 19'd51484, 19'd48594, 19'd45867
    };

    function automatic logic [3:0] top_key(input logic [NUM_KEYS-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [18:0] note_div(input logic [3:0] note, input logic [1:0] oct);
        return NOTE_DIV[note] >> oct;
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Key/button inputs and soundpath-facing outputs of the note sequencer.
// Level/pulse signals only; no handshake, the soundpath never stalls.
interface note_sequencer_if;
    import note_seq_pkg::*;

    logic [NUM_KEYS-1:0] key_i;
    logic                oct_up_i;
    logic                oct_dn_i;
    logic                mode_btn_i;
    logic                sample_now_o;
    logic [18:0]         divisor_o;
    logic [1:0]          mode_o;
    logic [3:0]          note_o;
    logic [1:0]          octave_o;
    logic                active_o;

    modport master (
        output key_i, oct_up_i, oct_dn_i, mode_btn_i,
        input  sample_now_o, divisor_o, mode_o, note_o, octave_o, active_o
    );

    modport slave (
        input  key_i, oct_up_i, oct_dn_i, mode_btn_i,
        output sample_now_o, divisor_o, mode_o, note_o, octave_o, active_o
    );
endinterface

// File: rtl/note_sequencer_key_arbiter.sv
// Picks one candidate note from the held keys: newest press, then the sounding note, then highest held.
// Purely combinational, zero latency; no backpressure.
module key_arbiter
    import note_seq_pkg::*;
(
    input  logic [NUM_KEYS-1:0] key,
    input  logic [NUM_KEYS-1:0] key_q,
    input  logic [3:0]          cur_note,
    input  logic                cur_on,
    output logic [3:0]          cand,
    output logic                cand_valid,
    output logic                new_press
);
    logic [NUM_KEYS-1:0] fresh;

    assign fresh     = key & ~key_q;
    assign new_press = |fresh;

    always_comb begin
        cand       = '0;
        cand_valid = 1'b1;
        if (new_press) begin
            cand = top_key(fresh);
        end else if (cur_on && key[cur_note]) begin
            cand = cur_note;
        end else if (|key) begin
            cand = top_key(key);
        end else begin
            cand_valid = 1'b0;
        end
    end
endmodule

// File: rtl/note_sequencer.sv
// Sample timer, octave/mode capture and voice FSM; audible state changes land only on sample boundaries.
// Outputs update one clock after the sample_now cycle; inputs are never backpressured.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int SAMPLE_PERIOD   = 256,
    parameter int MAX_OCT         = 3,
    parameter int RELEASE_SAMPLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    note_sequencer_if.slave   bus
);
    localparam int CW = $clog2(SAMPLE_PERIOD);
    localparam int RW = $clog2(RELEASE_SAMPLES + 1);

    logic [CW-1:0]       cnt;
    logic [NUM_KEYS-1:0] key_q;
    logic [3:0]          cand;
    logic                cand_valid;
    logic                new_press;
    logic [3:0]          pend_note;
    logic                pend_vld;
    logic [1:0]          pend_oct;
    logic [1:0]          pend_mode;
    logic [RW-1:0]       rel_cnt;
    state_t              state;
    logic                boundary;
    logic                load;
    logic [3:0]          sel_note;

    key_arbiter u_arb (
        .key        (bus.key_i),
        .key_q      (key_q),
        .cur_note   (bus.note_o),
        .cur_on     (bus.active_o),
        .cand       (cand),
        .cand_valid (cand_valid),
        .new_press  (new_press)
    );

    assign boundary = bus.sample_now_o;
    assign load     = cand_valid | pend_vld;

    // A press in the boundary cycle itself is newer than anything latched earlier.
    always_comb begin
        sel_note = cand;
        if (!new_press && pend_vld) sel_note = pend_note;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt              <= '0;
            key_q            <= '0;
            pend_note        <= '0;
            pend_vld         <= 1'b0;
            pend_oct         <= '0;
            pend_mode        <= '0;
            rel_cnt          <= '0;
            state            <= IDLE;
            bus.sample_now_o <= 1'b0;
            bus.divisor_o    <= '0;
            bus.mode_o       <= '0;
            bus.note_o       <= '0;
            bus.octave_o     <= '0;
            bus.active_o     <= 1'b0;
        end else begin
            cnt              <= cnt + 1'b1;
            bus.sample_now_o <= (cnt == CW'(SAMPLE_PERIOD - 2));
            key_q            <= bus.key_i;

            if (bus.oct_up_i && !bus.oct_dn_i && pend_oct != 2'(MAX_OCT)) begin
                pend_oct <= pend_oct + 1'b1;
            end else if (bus.oct_dn_i && !bus.oct_up_i && pend_oct != 2'd0) begin
                pend_oct <= pend_oct - 1'b1;
            end

            if (bus.mode_btn_i) pend_mode <= pend_mode + 1'b1;

            // Latch short presses so they still sound at the next boundary.
            if (boundary) begin
                pend_vld <= 1'b0;
            end else if (new_press) begin
                pend_vld  <= 1'b1;
                pend_note <= cand;
            end

            if (boundary) begin
                bus.mode_o   <= pend_mode;
                bus.octave_o <= pend_oct;
                if (load) begin
                    state         <= PLAY;
                    bus.note_o    <= sel_note;
                    bus.divisor_o <= note_div(sel_note, pend_oct);
                    bus.active_o  <= 1'b1;
                end else begin
                    case (state)
                        PLAY: begin
                            state   <= RELEASE;
                            rel_cnt <= '0;
                        end
                        RELEASE: begin
                            if (rel_cnt == RW'(RELEASE_SAMPLES - 1)) begin
                                state         <= IDLE;
                                bus.divisor_o <= '0;
                                bus.active_o  <= 1'b0;
                            end else begin
                                rel_cnt <= rel_cnt + 1'b1;
                            end
                        end
                        default: begin
                            state         <= IDLE;
                            bus.divisor_o <= '0;
                            bus.active_o  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Scenario tasks plus a randomized run, all checked against a strobe-level behavioural model.
module tb_note_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    note_sequencer_if bus ();

    note_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model state (what a listener would observe)
    int DIV_TAB [13] = '{91735, 86585, 81726, 77139, 72809, 68723, 64865,
                         61225, 57789, 54545, 51484, 48594, 45867};
    int m_cycles, m_snow, m_div, m_mode, m_note, m_oct, m_act;
    int m_rel, m_pmode, m_poct, m_prev, m_pend, m_pend_note;

    function automatic int top_of(input int v);
        int t;
        t = -1;
        for (int i = 0; i < 13; i++) if (v[i]) t = i;
        return t;
    endfunction

    task automatic model_step();
        int key, newp, cand, cv, sel;
        bit boundary;
        key = int'(bus.key_i);
        if (rst) begin
            m_cycles = 0; m_snow = 0; m_div = 0; m_mode = 0; m_note = 0; m_oct = 0;
            m_act = 0; m_rel = 0; m_pmode = 0; m_poct = 0; m_prev = 0; m_pend = 0; m_pend_note = 0;
            return;
        end
        boundary = (m_snow != 0);
        newp = key & ~m_prev & 32'h1fff;
        cv = 1;
        cand = 0;
        if (newp != 0) cand = top_of(newp);
        else if (m_act != 0 && key[m_note]) cand = m_note;
        else if (key != 0) cand = top_of(key);
        else cv = 0;
        if (boundary) begin
            m_mode = m_pmode;
            m_oct  = m_poct;
            if (cv != 0 || m_pend != 0) begin
                sel = (newp == 0 && m_pend != 0) ? m_pend_note : cand;
                m_note = sel;
                m_div  = DIV_TAB[sel] / (1 << m_poct);
                m_act  = 1;
                m_rel  = -1;
            end else if (m_act != 0) begin
                m_rel = m_rel + 1;          // -1 -> 0 marks entry into release
                if (m_rel == 64) begin
                    m_div = 0;
                    m_act = 0;
                end
            end
        end
        if (boundary) m_pend = 0;
        else if (newp != 0) begin
            m_pend = 1;
            m_pend_note = cand;
        end
        if (bus.oct_up_i && !bus.oct_dn_i && m_poct < 3) m_poct++;
        else if (bus.oct_dn_i && !bus.oct_up_i && m_poct > 0) m_poct--;
        if (bus.mode_btn_i) m_pmode = (m_pmode + 1) % 4;
        m_prev = key;
        m_cycles++;
        m_snow = ((m_cycles % 256) == 255) ? 1 : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (bus.sample_now_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.key_i = '0; bus.oct_up_i = 0; bus.oct_dn_i = 0; bus.mode_btn_i = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (bus.divisor_o !== 19'd0) begin bad++; $display("FAIL reset_div got=%0d want=0", bus.divisor_o); end
        total++; if (bus.mode_o !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d want=0", bus.mode_o); end
        total++; if (bus.note_o !== 4'd0) begin bad++; $display("FAIL reset_note got=%0d want=0", bus.note_o); end
        total++; if (bus.octave_o !== 2'd0) begin bad++; $display("FAIL reset_oct got=%0d want=0", bus.octave_o); end
        total++; if (bus.active_o !== 1'b0) begin bad++; $display("FAIL reset_active got=%0d want=0", bus.active_o); end
        total++; if (bus.sample_now_o !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%0d want=0", bus.sample_now_o); end
    endtask

    // Entered in the first cycle after the reset edge (cycle 1).
    task automatic test_timer();
        int first, seen, good_gap, consec, last;
        bit prev;
        first = 0; seen = 0; good_gap = 0; consec = 0; last = 0; prev = 0;
        for (int c = 1; c <= 256 * 12 && seen < 11; c++) begin
            if (c > 1) tick();
            if (bus.sample_now_o) begin
                if (prev) consec++;
                if (seen == 0) first = c;
                else if (c - last == 256) good_gap++;
                last = c;
                seen++;
            end
            prev = bus.sample_now_o;
        end
        total++; if (first != 256) begin bad++; $display("FAIL timer_first got=%0d want=256", first); end
        total++; if (good_gap != 10) begin bad++; $display("FAIL timer_period got=%0d want=10", good_gap); end
        total++; if (consec != 0) begin bad++; $display("FAIL timer_consec got=%0d want=0", consec); end
    endtask

    task automatic test_single_note();
        int changed;
        bit ok;
        changed = 0;
        repeat (100) tick();
        bus.key_i = 13'(1 << 9);
        bus.oct_up_i = 1'b1;
        tick();
        bus.oct_up_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (bus.divisor_o !== 19'd0 || bus.active_o !== 1'b0 || bus.octave_o !== 2'd0) changed++;
            if (bus.sample_now_o) ok = 1'b1;
            else tick();
        end
        tick();
        total++; if (!ok || changed != 0) begin bad++; $display("FAIL single_early got=%0d want=0 strobe=%0d", changed, ok); end
        total++; if (bus.divisor_o !== 19'd27272) begin bad++; $display("FAIL single_div got=%0d want=27272", bus.divisor_o); end
        total++; if (bus.note_o !== 4'd9) begin bad++; $display("FAIL single_note got=%0d want=9", bus.note_o); end
        total++; if (bus.octave_o !== 2'd1 || bus.active_o !== 1'b1) begin bad++; $display("FAIL single_oct_act got=%0d/%0d want=1/1", bus.octave_o, bus.active_o); end
    endtask

    task automatic test_priority();
        bit ok1, ok2, ok3;
        bus.oct_dn_i = 1'b1;
        bus.key_i = 13'b100;
        tick();
        bus.oct_dn_i = 1'b0;
        wait_strobe(ok1); tick();
        bus.key_i = 13'b101;
        wait_strobe(ok2); tick();
        total++; if (bus.note_o !== 4'd0 || bus.divisor_o !== 19'd91735) begin bad++; $display("FAIL prio_last got=%0d/%0d want=0/91735", bus.note_o, bus.divisor_o); end
        bus.key_i = 13'b100;
        wait_strobe(ok3); tick();
        total++; if (bus.note_o !== 4'd2 || bus.divisor_o !== 19'd81726) begin bad++; $display("FAIL prio_fallback got=%0d/%0d want=2/81726", bus.note_o, bus.divisor_o); end
        total++; if (!(ok1 && ok2 && ok3)) begin bad++; $display("FAIL prio_timeout got=0 want=1"); end
    endtask

    task automatic test_release();
        int strobes, mism;
        bit ok, ok2, ok3, done;
        strobes = 0; mism = 0; done = 0;
        bus.key_i = '0;
        wait_strobe(ok); tick();
        for (int i = 0; i < 256 * 70 && !done; i++) begin
            tick();
            if (bus.divisor_o !== 19'(m_div)) mism++;
            if (bus.divisor_o == 19'd0) done = 1;
            else if (bus.sample_now_o) strobes++;
        end
        total++; if (strobes != 64) begin bad++; $display("FAIL release_hold got=%0d want=64", strobes); end
        total++; if (bus.divisor_o !== 19'd0 || bus.active_o !== 1'b0) begin bad++; $display("FAIL release_silent got=%0d/%0d want=0/0", bus.divisor_o, bus.active_o); end
        total++; if (mism != 0 || !ok) begin bad++; $display("FAIL release_model got=%0d want=0", mism); end
        // retrigger during release
        bus.key_i = 13'(1 << 5);
        wait_strobe(ok); tick();
        bus.key_i = '0;
        wait_strobe(ok2); tick();
        strobes = 0;
        for (int i = 0; i < 256 * 40 && strobes < 30; i++) begin
            tick();
            if (bus.sample_now_o) strobes++;
        end
        repeat (10) tick();
        total++; if (bus.active_o !== 1'b1 || bus.divisor_o !== 19'd68723) begin bad++; $display("FAIL retrig_held got=%0d/%0d want=1/68723", bus.active_o, bus.divisor_o); end
        bus.key_i = 13'(1 << 12);
        wait_strobe(ok3); tick();
        total++; if (bus.divisor_o !== 19'd45867 || bus.note_o !== 4'd12) begin bad++; $display("FAIL retrig_div got=%0d/%0d want=45867/12", bus.divisor_o, bus.note_o); end
        wait_strobe(ok); tick();
        total++; if (!ok || !ok2 || !ok3 || bus.active_o !== 1'b1 || bus.divisor_o !== 19'd45867) begin bad++; $display("FAIL retrig_play got=%0d/%0d want=1/45867", bus.active_o, bus.divisor_o); end
    endtask

    task automatic test_sat_mode();
        bit ok1, ok2, ok3;
        repeat (5) begin
            bus.oct_up_i = 1'b1; tick();
            bus.oct_up_i = 1'b0; tick();
        end
        wait_strobe(ok1); tick();
        total++; if (bus.octave_o !== 2'd3 || bus.divisor_o !== 19'd5733) begin bad++; $display("FAIL sat_oct got=%0d/%0d want=3/5733", bus.octave_o, bus.divisor_o); end
        bus.oct_up_i = 1'b1; bus.oct_dn_i = 1'b1; tick();
        bus.oct_up_i = 1'b0; bus.oct_dn_i = 1'b0;
        wait_strobe(ok2); tick();
        total++; if (bus.octave_o !== 2'd3) begin bad++; $display("FAIL both_oct got=%0d want=3", bus.octave_o); end
        repeat (5) begin
            bus.mode_btn_i = 1'b1; tick();
            bus.mode_btn_i = 1'b0; tick();
        end
        total++; if (bus.mode_o !== 2'd0) begin bad++; $display("FAIL mode_early got=%0d want=0", bus.mode_o); end
        wait_strobe(ok3); tick();
        total++; if (!(ok1 && ok2 && ok3) || bus.mode_o !== 2'd1) begin bad++; $display("FAIL mode_wrap got=%0d want=1", bus.mode_o); end
    endtask

    task automatic test_random();
        int shown;
        shown = 0;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 29) == 0) bus.key_i = bus.key_i ^ 13'(1 << $urandom_range(0, 12));
            if ($urandom_range(0, 199) == 0) bus.key_i = '0;
            bus.oct_up_i   = ($urandom_range(0, 149) == 0);
            bus.oct_dn_i   = ($urandom_range(0, 149) == 0);
            bus.mode_btn_i = ($urandom_range(0, 99) == 0);
            rst            = ($urandom_range(0, 2999) == 0);
            tick();
            total++;
            if (bus.divisor_o !== 19'(m_div) || bus.note_o !== 4'(m_note) || bus.octave_o !== 2'(m_oct) ||
                bus.mode_o !== 2'(m_mode) || bus.active_o !== 1'(m_act) || bus.sample_now_o !== 1'(m_snow)) begin
                bad++;
                if (shown < 5) begin
                    shown++;
                    $display("FAIL random c=%0d got div=%0d note=%0d oct=%0d mode=%0d act=%0d sn=%0d want %0d %0d %0d %0d %0d %0d",
                             c, bus.divisor_o, bus.note_o, bus.octave_o, bus.mode_o, bus.active_o, bus.sample_now_o,
                             m_div, m_note, m_oct, m_mode, m_act, m_snow);
                end
            end
        end
        rst = 1'b0; bus.oct_up_i = 0; bus.oct_dn_i = 0; bus.mode_btn_i = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int first;
        first = 0;
        bus.key_i = '0;
        tick();
        bus.key_i = 13'(1 << 7);
        wait_strobe(ok); tick();
        total++; if (!ok || bus.active_o !== 1'b1) begin bad++; $display("FAIL midrst_play got=%0d want=1", bus.active_o); end
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.divisor_o !== 19'd0 || bus.active_o !== 1'b0 || bus.note_o !== 4'd0 || bus.octave_o !== 2'd0 || bus.mode_o !== 2'd0) begin
            bad++; $display("FAIL midrst_out got=%0d/%0d want=0/0", bus.divisor_o, bus.active_o); end
        for (int c = 1; c <= 400 && first == 0; c++) begin
            if (c > 1) tick();
            if (bus.sample_now_o) first = c;
        end
        total++; if (first != 256) begin bad++; $display("FAIL midrst_strobe got=%0d want=256", first); end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_single_note();
        test_priority();
        test_release();
        test_sat_mode();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Control block ahead of the soundpath datapath.
- Generates the sample_now strobe (one pulse every 256 clocks at 12 MHz).
- Arbitrates 13 note keys (one octave, C..C) down to a single voice and converts it to a 19-bit tone divisor, with octave shift.
- Sequences mode, divisor and gate changes so they only take effect on sample boundaries, and applies a short release hold so notes do not cut off mid-sample.

Parameters:
SAMPLE_PERIOD, 256, clocks between sample_now pulses (power of two, ≥4)
MAX_OCT, 3, highest octave shift (divisor >> octave)
RELEASE_SAMPLES, 64, sample strobes held after last key release before going silent

Ports:
clk  in  1  system clock, 12 MHz
rst  in  1  reset, synchronous, active-high
key_i  in  13  held-key vector, bit0=C3 .. bit12=C4; already synchronized/debounced
oct_up_i  in  1  one-cycle pulse, octave +1
oct_dn_i  in  1  one-cycle pulse, octave -1
mode_btn_i  in  1  one-cycle pulse, cycle waveform mode
sample_now_o  out  1  one-cycle sample strobe to soundpath
divisor_o  out  19  tone divisor to soundpath; 0 when silent
mode_o  out  2  waveform mode to soundpath
note_o  out  4  index of the sounding note, 0..12
octave_o  out  2  current octave shift
active_o  out  1  high while a note sounds (PLAY or RELEASE)

Behaviour:
- Reset is synchronous and active-high. One clock. At reset: all outputs 0, sample counter 0, state IDLE, key history 0, pending mode 0.
- Sample timer:
  - Free-running counter 0..SAMPLE_PERIOD-1.
  - sample_now_o is registered and high exactly when count == SAMPLE_PERIOD-1.
  - First pulse comes SAMPLE_PERIOD cycles after reset release; period is exactly SAMPLE_PERIOD.
- Key arbitration (combinational each cycle, into cand / cand_valid):
  - new = key_i & ~key_q, where key_q is the previous cycle's key_i.
  - If new ≠ 0: cand = highest-index set bit of new. Last-pressed wins.
  - Else if the current note is still held: cand = current note.
  - Else if key_i ≠ 0: cand = highest-index held key.
  - Else cand_valid = 0.
  - The latched candidate (pend_note) is updated on any cycle with a new press, so a press-and-release between boundaries is still honoured.
- Octave:
  - oct_up_i increments and oct_dn_i decrements, immediately.
  - Saturates at 0 and MAX_OCT.
  - Both pulses high in the same cycle → no change.
  - Pending until the next boundary.
- Mode:
  - mode_btn_i increments pend_mode, 3 wraps to 0.
  - mode_o loads pend_mode only on boundary cycles.
- Boundary cycle: the cycle in which sample_now_o is high. All of the following registers update on the clock edge ending that cycle and are visible the next cycle: divisor_o, mode_o, note_o, octave_o, active_o, state.
- FSM (evaluated only on boundary cycles):
  - IDLE: if cand_valid or pend_note pending → PLAY, load note. Otherwise divisor_o = 0, active_o = 0.
  - PLAY: if cand_valid → stay, reload note/octave (retrigger allowed). Else → RELEASE, rel_cnt = 0.
  - RELEASE: divisor_o holds the last value. If cand_valid → PLAY. Else rel_cnt++. When rel_cnt == RELEASE_SAMPLES-1 → IDLE, divisor_o = 0, active_o = 0.
- Divisor:
  - divisor_o = NOTE_DIV[note] >> octave.
  - 19-bit, truncating shift, no rounding.
- Boundaries and corner cases:
  - A key pressed and released entirely between boundaries still plays for at least one sample.
  - Reset asserted mid-note → silent on the next cycle, with no RELEASE phase.

Decomposition:
- Package note_seq_pkg holds:
  - state_t enum {IDLE, PLAY, RELEASE}
  - NOTE_DIV[0:12] 19-bit constants, round(12e6 / f): 91735, 86585, 81726, 77139, 72809, 68723, 64865, 61225, 57789, 54545, 51484, 48594, 45867
  - NUM_KEYS = 13
- One sub-module: key_arbiter, the combinational new-press detect and priority encoder producing cand/cand_valid. Everything else stays in note_sequencer.

Test Plan:
- Timer:
  - Stimulus: release reset, count cycles.
  - Required response: sample_now_o first high at cycle 256; thereafter every 256 cycles for 10 periods; never two consecutive cycles high.
- Single note with octave:
  - Stimulus: key_i = bit9 (A) and oct_up_i pulse, mid-period.
  - Required response: outputs unchanged until the boundary. Cycle after the boundary: divisor_o = 27272, note_o = 9, octave_o = 1, active_o = 1.
- Last-pressed priority:
  - Stimulus: hold bit2, then press bit0.
  - Required response: note_o = 0, divisor_o = 91735 (octave 0).
  - Stimulus: release bit0.
  - Required response: falls back to note_o = 2, divisor_o = 81726.
- Release and retrigger:
  - Stimulus: release all keys.
  - Required response: divisor_o held for 64 strobes, then 0 with active_o = 0.
  - Stimulus: repeat, but press bit12 at strobe 30 of the release.
  - Required response: divisor_o = 45867 at the next boundary; state PLAY.
- Saturation and mode wrap:
  - Stimulus: 5 oct_up_i pulses.
  - Required response: octave_o = 3.
  - Stimulus: oct_up_i and oct_dn_i together.
  - Required response: no change.
  - Stimulus: 5 mode_btn_i pulses within one period.
  - Required response: mode_o = 1 after the boundary.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during PLAY.
  - Required response: next cycle all outputs 0 and counter restarted; first sample_now_o 256 cycles later.
